// File: rtl/spi_slave_frame_buf.sv
// spi_slave_frame_buf
//   SPI mode-0 slave that exchanges up to F_NUM frames of F_SIZE bits per
//   chip-select window. TX frames are preloaded on tx_data_i and driven
//   combinationally on MISO; received frames land in rx_data_o slots.
//
// Ports
//   SCLK         serial clock, all registers update on its rising edge
//   rst          asynchronous active-high reset
//   CS           active-low chip select; high = idle / abort
//   MOSI         serial data from master
//   MISO         serial data to master (combinational)
//   tx_data_i    F_NUM packed TX frames, frame k at [k*F_SIZE +: F_SIZE]
//   rx_data_o    F_NUM packed RX frames, same packing
//   f_cnt        completed frames in the current/last window
//   frame_done_o high after the edge that completes a frame
//   overrun_o    sticky, bits clocked after F_NUM frames
//   abort_o      sticky, CS rose mid-frame
module spi_slave_frame_buf #(
  parameter int F_SIZE    = 8,
  parameter int F_NUM     = 4,
  parameter int LSB_FIRST = 0,
  parameter int C_SIZE    = $clog2(F_SIZE),
  parameter int FC_SIZE   = $clog2(F_NUM) + 1
) (
  input  logic                      SCLK,
  input  logic                      rst,
  input  logic                      CS,
  input  logic                      MOSI,
  output logic                      MISO,
  input  logic [F_NUM*F_SIZE-1:0]   tx_data_i,
  output logic [F_NUM*F_SIZE-1:0]   rx_data_o,
  output logic [FC_SIZE-1:0]        f_cnt,
  output logic                      frame_done_o,
  output logic                      overrun_o,
  output logic                      abort_o
);

  localparam int                 FI_W       = (F_NUM > 1) ? $clog2(F_NUM) : 1;
  localparam logic [C_SIZE-1:0]  LAST_BIT   = C_SIZE'(F_SIZE - 1);
  localparam logic [FC_SIZE-1:0] NUM_FRAMES = FC_SIZE'(F_NUM);

  logic                active;
  logic                active_clr;
  logic [C_SIZE-1:0]   bit_cnt;
  logic [C_SIZE-1:0]   bc;
  logic [C_SIZE-1:0]   bp;
  logic [FC_SIZE-1:0]  fi;
  logic [FI_W-1:0]     fi_idx;
  logic                in_range;
  logic [F_SIZE-1:0]   shift_reg;
  logic [F_SIZE-1:0]   assembled;
  logic [F_SIZE-1:0]   tx_frames [F_NUM];
  logic [F_SIZE-1:0]   rx_frames [F_NUM];

  // Unpack TX frames and pack RX frames so slot addressing stays simple.
  for (genvar g = 0; g < F_NUM; g++) begin : g_slots
    assign tx_frames[g]                     = tx_data_i[g*F_SIZE +: F_SIZE];
    assign rx_data_o[g*F_SIZE +: F_SIZE]    = rx_frames[g];
  end

  // Window-active flag: dropping CS ends the window immediately, so the
  // first edge of the next window sees stale counters as zero.
  assign active_clr = rst | CS;

  always_ff @(posedge SCLK or posedge active_clr) begin
    if (active_clr) active <= 1'b0;
    else            active <= 1'b1;
  end

  // Effective counters and the bit position addressed this cycle.
  always_comb begin
    fi        = active ? f_cnt : '0;
    bc        = active ? bit_cnt : '0;
    bp        = (LSB_FIRST != 0) ? bc : (LAST_BIT - bc);
    in_range  = (fi < NUM_FRAMES);
    fi_idx    = fi[FI_W-1:0];
    assembled = shift_reg;
    assembled[bp] = MOSI;
  end

  // Mode-0: the addressed bit is visible before the first rising edge.
  assign MISO = (!CS && in_range) ? tx_frames[fi_idx][bp] : 1'b0;

  // Receive path. A nonzero bit_cnt seen while the window is inactive means
  // the previous window ended mid-frame; the partial frame is dropped.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      bit_cnt      <= '0;
      f_cnt        <= '0;
      shift_reg    <= '0;
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
      abort_o      <= 1'b0;
      for (int i = 0; i < F_NUM; i++) rx_frames[i] <= '0;
    end else begin
      if (!active && (bit_cnt != '0)) abort_o <= 1'b1;
      if (!CS) begin
        if (in_range) begin
          shift_reg <= assembled;
          if (bc == LAST_BIT) begin
            rx_frames[fi_idx] <= assembled;
            bit_cnt           <= '0;
            f_cnt             <= fi + 1'b1;
            frame_done_o      <= 1'b1;
          end else begin
            bit_cnt      <= bc + 1'b1;
            f_cnt        <= fi;
            frame_done_o <= 1'b0;
          end
        end else begin
          overrun_o    <= 1'b1;
          frame_done_o <= 1'b0;
        end
      end
    end
  end

endmodule
